// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchronizer, debouncer, press/release strobes and auto-repeat
// Ports:
//   clk           board clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   btn_raw       raw asynchronous button inputs, 1 = pressed
//   btn_level     debounced registered level
//   press_pulse   one-cycle strobe when a press is accepted
//   release_pulse one-cycle strobe when a release is accepted
//   repeat_pulse  one-cycle strobe per auto-repeat interval while held
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES) > $clog2(REPEAT_CYCLES) ?
                        $clog2(HOLD_CYCLES) : $clog2(REPEAT_CYCLES);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    logic [NUM_BTN-1:0] r_s1, r_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s  <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s  <= r_s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DW-1:0] r_cnt;
        logic          r_level, r_press, r_release, r_repeat;
        state_t        r_state, w_state_nx;
        logic [HW-1:0] r_hcnt, w_hcnt_nx;
        logic          w_rep_nx, w_diff, w_accept, w_rise, w_fall;

        // the count only survives while the synchronized input disagrees with the level
        assign w_diff   = r_s[i] ^ r_level;
        assign w_accept = w_diff && (r_cnt == DB_MAX);
        assign w_rise   = w_accept && r_s[i];
        assign w_fall   = w_accept && !r_s[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
                r_state   <= IDLE;
                r_hcnt    <= '0;
            end else begin
                r_cnt     <= (!w_diff || w_accept) ? '0 : r_cnt + 1'b1;
                r_level   <= w_accept ? r_s[i] : r_level;
                r_press   <= w_rise;
                r_release <= w_fall;
                r_repeat  <= w_rep_nx;
                r_state   <= w_state_nx;
                r_hcnt    <= w_hcnt_nx;
            end
        end

        // release wins over any coincident repeat boundary
        always_comb begin
            w_state_nx = r_state;
            w_hcnt_nx  = r_hcnt + 1'b1;
            w_rep_nx   = 1'b0;
            if (w_fall) begin
                w_state_nx = IDLE;
                w_hcnt_nx  = '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        w_hcnt_nx  = '0;
                        w_state_nx = w_rise ? HELD : IDLE;
                    end
                    HELD: begin
                        if (r_hcnt == HOLD_MAX) begin
                            w_state_nx = REPEAT;
                            w_hcnt_nx  = '0;
                            w_rep_nx   = 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (r_hcnt == REP_MAX) begin
                            w_hcnt_nx = '0;
                            w_rep_nx  = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nx = IDLE;
                        w_hcnt_nx  = '0;
                    end
                endcase
            end
        end

        assign btn_level[i]     = r_level;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_release;
        assign repeat_pulse[i]  = r_repeat;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with an event scoreboard for button_conditioner
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] btn_level, press_pulse, release_pulse, repeat_pulse;

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int         cyc;
        logic [1:0] pr, rl, rp, lv;
    } ev_t;
    ev_t q[$];
    ev_t m_ev;

    int n_pass = 0, n_tot = 0;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, ecnt);
    endfunction

    function automatic void push(int c, logic [1:0] pr, logic [1:0] rl, logic [1:0] rp, logic [1:0] lv);
        ev_t e;
        e.cyc = c; e.pr = pr; e.rl = rl; e.rp = rp; e.lv = lv;
        q.push_back(e);
    endfunction

    task automatic wait_edge(input int e);
        while (ecnt < e) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_level"}, int'(btn_level), 0);
        chk({tag, "_press"}, int'(press_pulse), 0);
        chk({tag, "_release"}, int'(release_pulse), 0);
        chk({tag, "_repeat"}, int'(repeat_pulse), 0);
    endtask

    always @(negedge clk) begin
        if ((press_pulse | release_pulse | repeat_pulse) != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", int'({press_pulse, release_pulse, repeat_pulse}), 0);
            end else begin
                m_ev = q.pop_front();
                chk("event_edge", ecnt, m_ev.cyc);
                chk("event_outputs", int'({press_pulse, release_pulse, repeat_pulse, btn_level}),
                    int'({m_ev.pr, m_ev.rl, m_ev.rp, m_ev.lv}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: edge %0d reached without completion, expected finish", ecnt);
        $fatal(1);
    end

    int e1, p, rs;
    int seq [10] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // clean press, long hold with auto-repeat, release off a boundary
        @(negedge clk);
        e1 = ecnt + 1; p = e1 + 5;
        btn_raw = 2'b01;
        push(p,      2'b01, 2'b00, 2'b00, 2'b01);
        push(p + 8,  2'b00, 2'b00, 2'b01, 2'b01);
        push(p + 11, 2'b00, 2'b00, 2'b01, 2'b01);
        push(p + 14, 2'b00, 2'b00, 2'b01, 2'b01);
        push(p + 17, 2'b00, 2'b00, 2'b01, 2'b01);
        push(p + 18, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_edge(p + 12);
        btn_raw = 2'b00;
        wait_edge(p + 30);

        // bounce with no run of 4, then a 10-cycle hold
        e1 = ecnt + 1;
        push(e1 + 14, 2'b01, 2'b00, 2'b00, 2'b01);
        push(e1 + 22, 2'b00, 2'b00, 2'b01, 2'b01);
        push(e1 + 24, 2'b00, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = (seq[i] != 0);
            @(negedge clk);
        end
        wait_edge(e1 + 18);
        btn_raw = 2'b00;
        wait_edge(e1 + 40);

        // level falls on the same edge as a repeat boundary
        @(negedge clk);
        e1 = ecnt + 1; p = e1 + 5;
        btn_raw = 2'b01;
        push(p,      2'b01, 2'b00, 2'b00, 2'b01);
        push(p + 8,  2'b00, 2'b00, 2'b01, 2'b01);
        push(p + 11, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_edge(e1 + 10);
        btn_raw = 2'b00;
        wait_edge(p + 25);

        // simultaneous press, staggered release
        @(negedge clk);
        e1 = ecnt + 1;
        btn_raw = 2'b11;
        push(e1 + 5,  2'b11, 2'b00, 2'b00, 2'b11);
        push(e1 + 11, 2'b00, 2'b01, 2'b00, 2'b10);
        push(e1 + 12, 2'b00, 2'b10, 2'b00, 2'b00);
        wait_edge(e1 + 5);
        btn_raw = 2'b10;
        wait_edge(e1 + 6);
        btn_raw = 2'b00;
        wait_edge(e1 + 30);

        // reset during REPEAT with the button still held
        @(negedge clk);
        e1 = ecnt + 1; p = e1 + 5;
        btn_raw = 2'b01;
        push(p,      2'b01, 2'b00, 2'b00, 2'b01);
        push(p + 8,  2'b00, 2'b00, 2'b01, 2'b01);
        push(p + 11, 2'b00, 2'b00, 2'b01, 2'b01);
        wait_edge(p + 11);
        rst = 1'b1;
        rs = p + 12;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midreset");
        push(rs + 6,  2'b01, 2'b00, 2'b00, 2'b01);
        push(rs + 14, 2'b00, 2'b00, 2'b01, 2'b01);
        push(rs + 17, 2'b00, 2'b00, 2'b01, 2'b01);
        push(rs + 19, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_edge(rs + 13);
        btn_raw = 2'b00;
        wait_edge(rs + 35);

        chk("pending_events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
